mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Single-port scheduler for the byte-wide external RAM/IO bus. It is shared by the instruction fetcher (32-bit reads) and the load/store queue (1/2/4-byte reads and writes).
- Grants one requester at a time and sequences multi-byte accesses as consecutive byte transfers.
- Assembles or splits little-endian words.
- Honours io_buffer_full for UART writes and aborts speculative reads on rollback.
- Sits between fetcher/LSqueue and the cpu top-level mem_* pins.

Parameters:
IO_HI_BITS, 2'b11, value of address[17:16] that selects I/O space
MAX_BYTES, 4, maximum bytes per transaction

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ena  in  1  ready; when low all state frozen
in_rollback  in  1  misprediction flush
io_buffer_full  in  1  UART tx buffer full
in_fetcher_ena  in  1  fetch request, level, held until ok
in_fetcher_addr  in  32  fetch address
out_fetcher_ok  out  1  one-cycle done pulse
out_fetcher_data  out  32  fetched instruction, valid with ok
in_ls_ena  in  1  LS request, level, held until ok
in_ls_iswrite  in  1  1 = store
in_ls_addr  in  32  LS address
in_ls_data  in  32  store data, low bytes used
in_ls_size  in  3  byte count: 1, 2 or 4
out_ls_ok  out  1  one-cycle done pulse
out_ls_data  out  32  load data, zero-extended, valid with ok
out_ram_rd_wt_flag  out  1  1 = write
out_ram_addr  out  32  byte address
out_ram_data  out  8  write byte
in_ram_data  in  8  read byte, valid one cycle after address

Behaviour:
- Reset (rst high at an edge): state IDLE, byte counter 0, last_grant = LS so that fetch wins the first contention. All outputs are 0.
- States:
  - IDLE: when requests arrive, grant one and go to READ or WRITE. Latch base address, size (fetch = 4), write data and owner.
  - READ and WRITE: byte sequencing (detailed below).
  - DONE: ok is high for exactly this one cycle. Requests are ignored in DONE. Next state is IDLE.
- Arbitration in IDLE:
  - Single requester: it is granted.
  - Both requesting: the one not in last_grant is granted.
  - last_grant updates on each grant.
- READ, granted at edge E0:
  - out_ram_addr = base + k during cycle [Ek, Ek+1), for k = 0..N-1. rd_wt_flag = 0.
  - Byte k is sampled from in_ram_data at edge Ek+2 into bits [8k+7:8k]. Unused upper bytes are 0.
  - The final byte is captured at E(N+1), which enters DONE. ok and data are high in [E(N+1), E(N+2)). A 4-byte read has ok in [E5, E6).
- WRITE:
  - Byte k is driven during [Ek, Ek+1) with rd_wt_flag = 1, addr = base + k and data = in_ls_data[8k+7:8k].
  - DONE is entered at EN.
- IO stall:
  - Applies during WRITE when base[17:16] == IO_HI_BITS and io_buffer_full is high.
  - rd_wt_flag = 0, out_ram_addr = 0, and the counter holds. The byte is issued in the first cycle io_buffer_full is low.
- Outside an active transfer cycle: rd_wt_flag = 0 and out_ram_addr = 0.
- Rollback:
  - in_rollback high in READ (either owner) or in DONE of a read: next state is IDLE and no ok pulse is produced. Captured data is discarded.
  - WRITE is never aborted because stores are committed. It completes and pulses out_ls_ok.
  - Rollback in IDLE blocks granting that cycle.
- ena low:
  - State, counter, latched data and outputs are held. rd_wt_flag is forced 0.
  - Resumption continues exactly where frozen, including the pending sample.
- Address arithmetic: base + k is 32-bit, wrapping, with no alignment check.
- in_ls_size values other than 1, 2 or 4 are treated as 4.

Decomposition:
- Shared defines header (existing): DATA_WIDTH, RAM_WIDTH, plus new localparams ST_IDLE/ST_READ/ST_WRITE/ST_DONE, OWNER_FETCH/OWNER_LS, and the IO address-select constant.
- No natural sub-module: counter, byte assembly and arbitration stay in one module of about 200 lines.

Test Plan:
- Fetch 0x100, RAM bytes 13,05,10,00 -> addr 0x100..0x103 in cycles E0..E3, wr = 0; out_fetcher_ok in [E5, E6) with data 0x00100513; out_ls_ok stays 0.
- Fetch and LS request on the same edge right after reset -> fetch granted first; LS granted in the IDLE cycle after fetch DONE; a second simultaneous contention grants fetch.
- LS write size 2, data 0x0000BEEF, addr 0x204 -> (0x204, EF, wr = 1) then (0x205, BE, wr = 1); out_ls_ok in [E2, E3).
- LS write size 1, 0x41 to 0x30000, io_buffer_full high for 3 cycles -> wr = 0 and addr = 0 for those 3 cycles; byte issued in the 4th cycle; ok the following cycle.
- Rollback at cnt = 2 of a fetch -> IDLE next cycle, no ok; a new fetch to 0x200 returns the correct word. Rollback during a 4-byte store -> all 4 bytes are written and out_ls_ok pulses.
- ena low for 2 cycles mid-read at k = 1 -> outputs frozen, wr = 0; final data identical to the unpaused read, with ok delayed by exactly 2 cycles.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide memory bus arbiter: widths, FSM states,
// requester identities and the I/O space selector.
package mem_arbiter_pkg;

    localparam int         DATA_WIDTH = 32;
    localparam int         RAM_WIDTH  = 8;
    localparam logic [1:0] IO_SEL     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWNER_FETCH,
        OWNER_LS
    } owner_t;

    // Illegal sizes are widened to a full word.
    function automatic logic [2:0] size_to_bytes(input logic [2:0] size);
        case (size)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port scheduler for the byte-wide RAM/IO bus shared by the instruction
// fetcher and the load/store queue; sequences little-endian multi-byte accesses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [1:0] IO_HI_BITS = IO_SEL,
    parameter int         MAX_BYTES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_rollback,
    input  logic                  io_buffer_full,
    input  logic                  in_fetcher_ena,
    input  logic [DATA_WIDTH-1:0] in_fetcher_addr,
    output logic                  out_fetcher_ok,
    output logic [DATA_WIDTH-1:0] out_fetcher_data,
    input  logic                  in_ls_ena,
    input  logic                  in_ls_iswrite,
    input  logic [DATA_WIDTH-1:0] in_ls_addr,
    input  logic [DATA_WIDTH-1:0] in_ls_data,
    input  logic [2:0]            in_ls_size,
    output logic                  out_ls_ok,
    output logic [DATA_WIDTH-1:0] out_ls_data,
    output logic                  out_ram_rd_wt_flag,
    output logic [DATA_WIDTH-1:0] out_ram_addr,
    output logic [RAM_WIDTH-1:0]  out_ram_data,
    input  logic [RAM_WIDTH-1:0]  in_ram_data
);

    localparam int CNT_W = $clog2(MAX_BYTES + 2);
    localparam int IDX_W = $clog2(MAX_BYTES);

    state_t                               state;
    owner_t                               owner;
    owner_t                               last_grant;
    logic [CNT_W-1:0]                     cnt;
    logic [CNT_W-1:0]                     nbytes;
    logic [DATA_WIDTH-1:0]                base;
    logic [MAX_BYTES-1:0][RAM_WIDTH-1:0]  wbytes;
    logic [MAX_BYTES-1:0][RAM_WIDTH-1:0]  rbytes;
    logic [MAX_BYTES-1:0][RAM_WIDTH-1:0]  rd_word;
    logic                                 is_write;
    logic                                 wr_q;
    logic                                 fetch_ok_q;
    logic                                 ls_ok_q;

    logic             grant_fetch;
    logic             grant_ls;
    logic             stall_req;
    logic             stall;
    logic [CNT_W-1:0] cnt_p1;
    logic [CNT_W-1:0] cnt_m1;

    assign grant_fetch = in_fetcher_ena && (!in_ls_ena || last_grant == OWNER_LS);
    assign grant_ls    = in_ls_ena && !grant_fetch;
    assign stall_req   = (in_ls_addr[17:16] == IO_HI_BITS) && io_buffer_full;
    assign stall       = (base[17:16] == IO_HI_BITS) && io_buffer_full;
    assign cnt_p1      = cnt + CNT_W'(1);
    assign cnt_m1      = cnt - CNT_W'(1);

    // Byte sampled this edge merged into the word so the last byte lands with ok.
    always_comb begin
        rd_word = rbytes;
        rd_word[cnt_m1[IDX_W-1:0]] = in_ram_data;
    end

    // A frozen pipeline must never strobe a write; a flushed read never reports.
    assign out_ram_rd_wt_flag = wr_q & ena;
    assign out_fetcher_ok     = fetch_ok_q & ~in_rollback;
    assign out_ls_ok          = ls_ok_q & ~(in_rollback & ~is_write);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            owner            <= OWNER_FETCH;
            last_grant       <= OWNER_LS;
            cnt              <= '0;
            nbytes           <= '0;
            base             <= '0;
            wbytes           <= '0;
            rbytes           <= '0;
            is_write         <= 1'b0;
            wr_q             <= 1'b0;
            fetch_ok_q       <= 1'b0;
            ls_ok_q          <= 1'b0;
            out_ram_addr     <= '0;
            out_ram_data     <= '0;
            out_fetcher_data <= '0;
            out_ls_data      <= '0;
        end else if (ena) begin
            fetch_ok_q <= 1'b0;
            ls_ok_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wr_q         <= 1'b0;
                    out_ram_addr <= '0;
                    out_ram_data <= '0;
                    if (!in_rollback && (grant_fetch || grant_ls)) begin
                        cnt    <= '0;
                        rbytes <= '0;
                        if (grant_fetch) begin
                            owner        <= OWNER_FETCH;
                            last_grant   <= OWNER_FETCH;
                            base         <= in_fetcher_addr;
                            nbytes       <= CNT_W'(MAX_BYTES);
                            is_write     <= 1'b0;
                            out_ram_addr <= in_fetcher_addr;
                            state        <= ST_READ;
                        end else begin
                            owner      <= OWNER_LS;
                            last_grant <= OWNER_LS;
                            base       <= in_ls_addr;
                            nbytes     <= CNT_W'(size_to_bytes(in_ls_size));
                            is_write   <= in_ls_iswrite;
                            wbytes     <= in_ls_data;
                            if (!in_ls_iswrite) begin
                                out_ram_addr <= in_ls_addr;
                                state        <= ST_READ;
                            end else begin
                                state <= ST_WRITE;
                                // Byte 0 goes out on the grant edge unless the UART is full.
                                if (!stall_req) begin
                                    wr_q         <= 1'b1;
                                    out_ram_addr <= in_ls_addr;
                                    out_ram_data <= in_ls_data[RAM_WIDTH-1:0];
                                    cnt          <= CNT_W'(1);
                                end
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (in_rollback) begin
                        state        <= ST_IDLE;
                        cnt          <= '0;
                        out_ram_addr <= '0;
                    end else begin
                        cnt          <= cnt_p1;
                        out_ram_addr <= (cnt_p1 < nbytes) ? base + DATA_WIDTH'(cnt_p1) : '0;
                        if (cnt != '0)
                            rbytes[cnt_m1[IDX_W-1:0]] <= in_ram_data;
                        if (cnt == nbytes) begin
                            state <= ST_DONE;
                            cnt   <= '0;
                            if (owner == OWNER_FETCH) begin
                                fetch_ok_q       <= 1'b1;
                                out_fetcher_data <= rd_word;
                            end else begin
                                ls_ok_q     <= 1'b1;
                                out_ls_data <= rd_word;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (cnt == nbytes) begin
                        wr_q         <= 1'b0;
                        out_ram_addr <= '0;
                        out_ram_data <= '0;
                        cnt          <= '0;
                        ls_ok_q      <= 1'b1;
                        state        <= ST_DONE;
                    end else if (stall) begin
                        wr_q         <= 1'b0;
                        out_ram_addr <= '0;
                        out_ram_data <= '0;
                    end else begin
                        wr_q         <= 1'b1;
                        out_ram_addr <= base + DATA_WIDTH'(cnt);
                        out_ram_data <= wbytes[cnt[IDX_W-1:0]];
                        cnt          <= cnt_p1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
